// File: rtl/m2_block_scheduler_if.sv
// Engine handshake, block base address and SRAM ownership bundle between the
// M2 block scheduler (master) and its fetch/compute/write engines (slave).
interface m2_block_scheduler_if;
  logic        FS_start;
  logic        CT_start;
  logic        CS_start;
  logic        WS_start;
  logic        FS_done;
  logic        CT_done;
  logic        CS_done;
  logic        WS_done;
  logic [17:0] FS_base_addr;
  logic [17:0] WS_base_addr;
  logic        WS_y_seg;
  logic        FS_sram_req;
  logic        WS_sram_req;
  logic        FS_sram_grant;
  logic        WS_sram_grant;

  modport master (
    output FS_start, CT_start, CS_start, WS_start,
    output FS_base_addr, WS_base_addr, WS_y_seg,
    output FS_sram_grant, WS_sram_grant,
    input  FS_done, CT_done, CS_done, WS_done,
    input  FS_sram_req, WS_sram_req
  );

  modport slave (
    input  FS_start, CT_start, CS_start, WS_start,
    input  FS_base_addr, WS_base_addr, WS_y_seg,
    input  FS_sram_grant, WS_sram_grant,
    output FS_done, CT_done, CS_done, WS_done,
    output FS_sram_req, WS_sram_req
  );
endinterface

// File: rtl/m2_block_scheduler.sv
// Pipelines fetch-S', compute-T, compute-S and write-S over the 2400 IDCT blocks of a frame.
// Defining M2_SCHED_PERF_CNT_EN adds the M2_cycles frame cycle counter output.
module m2_block_scheduler (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Enable,
  m2_block_scheduler_if.master eng,
  output logic                 M2_done,
  output logic                 M2_err
`ifdef M2_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]          M2_cycles
`endif
);
  // state | meaning
  // IDLE  | waiting for Enable
  // LI_FS | lead-in: fetch block 0 only
  // PH_A  | compute T of block n, write S of block n-1
  // PH_B  | compute S of block n, fetch block n+1
  // LO_WS | lead-out: write block 2399
  // DONE  | one-cycle frame-complete pulse
  typedef enum logic [2:0] {IDLE, LI_FS, PH_A, PH_B, LO_WS, DONE} state_t;

  typedef struct packed {
    logic [1:0] seg;
    logic [4:0] row;
    logic [5:0] col;
  } pos_t;

  localparam logic [11:0] LAST_BLK = 12'd2399;

  function automatic logic [17:0] fs_addr(input pos_t p);
    logic [17:0] r, c;
    r = {13'd0, p.row};
    c = {12'd0, p.col};
    case (p.seg)
      2'd0:    fs_addr = 18'd76800  + r * 18'd2560 + c * 18'd8;
      2'd1:    fs_addr = 18'd153600 + r * 18'd1280 + c * 18'd8;
      default: fs_addr = 18'd192000 + r * 18'd1280 + c * 18'd8;
    endcase
  endfunction

  function automatic logic [17:0] ws_addr(input pos_t p);
    logic [17:0] r, c;
    r = {13'd0, p.row};
    c = {12'd0, p.col};
    case (p.seg)
      2'd0:    ws_addr = r * 18'd1280 + c * 18'd4;
      2'd1:    ws_addr = 18'd38400 + r * 18'd640 + c * 18'd4;
      default: ws_addr = 18'd57600 + r * 18'd640 + c * 18'd4;
    endcase
  endfunction

  // Y is 40 blocks wide, U and V 20; seg steps past V after the last block and is cleared on Enable.
  function automatic pos_t pos_next(input pos_t p);
    pos_t n;
    n = p;
    if (p.col == ((p.seg == 2'd0) ? 6'd39 : 6'd19)) begin
      n.col = 6'd0;
      if (p.row == 5'd29) begin
        n.row = 5'd0;
        n.seg = p.seg + 2'd1;
      end else begin
        n.row = p.row + 5'd1;
      end
    end else begin
      n.col = p.col + 6'd1;
    end
    return n;
  endfunction

  state_t      state;
  logic [11:0] blk;
  pos_t        fs_pos, ws_pos;
  logic        fs_flag, ct_flag, cs_flag, ws_flag;
  logic        fs_start_q, ct_start_q, cs_start_q, ws_start_q;
  logic [17:0] fs_base_q, ws_base_q;
  logic        ws_y_q, fs_own, ws_own;
  logic        fs_exp, ct_exp, cs_exp, ws_exp;
  logic        fs_ok, ct_ok, cs_ok, ws_ok;
  logic        in_phase, advance, proto_err;

  // A done counts only if its engine was started this phase, has not reported yet,
  // and is not arriving in the start cycle itself.
  always_comb begin
    fs_exp    = (state == LI_FS) || ((state == PH_B) && (blk != LAST_BLK));
    ct_exp    = (state == PH_A);
    cs_exp    = (state == PH_B);
    ws_exp    = ((state == PH_A) && (blk != 12'd0)) || (state == LO_WS);
    fs_ok     = eng.FS_done && fs_exp && !fs_flag && !fs_start_q;
    ct_ok     = eng.CT_done && ct_exp && !ct_flag && !ct_start_q;
    cs_ok     = eng.CS_done && cs_exp && !cs_flag && !cs_start_q;
    ws_ok     = eng.WS_done && ws_exp && !ws_flag && !ws_start_q;
    proto_err = (eng.FS_done && !fs_ok) || (eng.CT_done && !ct_ok) ||
                (eng.CS_done && !cs_ok) || (eng.WS_done && !ws_ok);
    in_phase  = state inside {LI_FS, PH_A, PH_B, LO_WS};
    advance   = in_phase &&
                (!fs_exp || fs_flag || fs_ok) && (!ct_exp || ct_flag || ct_ok) &&
                (!cs_exp || cs_flag || cs_ok) && (!ws_exp || ws_flag || ws_ok);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      blk        <= '0;
      fs_pos     <= '0;
      ws_pos     <= '0;
      fs_flag    <= 1'b0;
      ct_flag    <= 1'b0;
      cs_flag    <= 1'b0;
      ws_flag    <= 1'b0;
      fs_start_q <= 1'b0;
      ct_start_q <= 1'b0;
      cs_start_q <= 1'b0;
      ws_start_q <= 1'b0;
      fs_base_q  <= '0;
      ws_base_q  <= '0;
      ws_y_q     <= 1'b0;
      fs_own     <= 1'b0;
      ws_own     <= 1'b0;
      M2_done    <= 1'b0;
      M2_err     <= 1'b0;
    end else begin
      fs_start_q <= 1'b0;
      ct_start_q <= 1'b0;
      cs_start_q <= 1'b0;
      ws_start_q <= 1'b0;
      M2_done    <= 1'b0;
      if (proto_err) M2_err <= 1'b1;
      if (fs_ok) fs_pos <= pos_next(fs_pos);
      if (ws_ok) ws_pos <= pos_next(ws_pos);
      if (advance) begin
        fs_flag <= 1'b0;
        ct_flag <= 1'b0;
        cs_flag <= 1'b0;
        ws_flag <= 1'b0;
      end else begin
        if (fs_ok) fs_flag <= 1'b1;
        if (ct_ok) ct_flag <= 1'b1;
        if (cs_ok) cs_flag <= 1'b1;
        if (ws_ok) ws_flag <= 1'b1;
      end
      case (state)
        IDLE: if (Enable) begin
          state      <= LI_FS;
          fs_start_q <= 1'b1;
          fs_base_q  <= fs_addr('0);
          fs_pos     <= '0;
          ws_pos     <= '0;
          blk        <= '0;
          fs_own     <= 1'b1;
          ws_own     <= 1'b0;
        end
        LI_FS: if (advance) begin
          state      <= PH_A;
          ct_start_q <= 1'b1;
          fs_own     <= 1'b0;
          ws_own     <= 1'b1;
        end
        PH_A: if (advance) begin
          state      <= PH_B;
          cs_start_q <= 1'b1;
          fs_own     <= 1'b1;
          ws_own     <= 1'b0;
          if (blk != LAST_BLK) begin
            fs_start_q <= 1'b1;
            fs_base_q  <= fs_addr(fs_pos);
          end
        end
        PH_B: if (advance) begin
          ws_start_q <= 1'b1;
          ws_base_q  <= ws_addr(ws_pos);
          ws_y_q     <= (ws_pos.seg == 2'd0);
          fs_own     <= 1'b0;
          ws_own     <= 1'b1;
          if (blk == LAST_BLK) begin
            state <= LO_WS;
          end else begin
            state      <= PH_A;
            ct_start_q <= 1'b1;
            blk        <= blk + 12'd1;
          end
        end
        LO_WS: if (advance) begin
          state   <= DONE;
          M2_done <= 1'b1;
          ws_own  <= 1'b0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign eng.FS_start      = fs_start_q;
  assign eng.CT_start      = ct_start_q;
  assign eng.CS_start      = cs_start_q;
  assign eng.WS_start      = ws_start_q;
  assign eng.FS_base_addr  = fs_base_q;
  assign eng.WS_base_addr  = ws_base_q;
  assign eng.WS_y_seg      = ws_y_q;
  assign eng.FS_sram_grant = eng.FS_sram_req & fs_own;
  assign eng.WS_sram_grant = eng.WS_sram_req & ws_own;

`ifdef M2_SCHED_PERF_CNT_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      M2_cycles <= '0;
    end else if ((state == IDLE) && Enable) begin
      M2_cycles <= 32'd1;
    end else if (state != IDLE) begin
      M2_cycles <= M2_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_m2_block_scheduler.sv
// Directed bench for m2_block_scheduler: latency-programmable engine responders,
// start/done/grant monitor, and a linear sequence of checked frame scenarios.
module tb_m2_block_scheduler;
  logic Clock = 1'b0;
  logic Resetn, Enable, M2_done, M2_err;
  logic fs_req, ws_req, ws_stray, frame_clr;
`ifdef M2_SCHED_PERF_CNT_EN
  logic [31:0] M2_cycles;
`endif

  m2_block_scheduler_if bus ();

  m2_block_scheduler dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Enable  (Enable),
    .eng     (bus),
    .M2_done (M2_done),
    .M2_err  (M2_err)
`ifdef M2_SCHED_PERF_CNT_EN
    ,
    .M2_cycles (M2_cycles)
`endif
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  int          lat [4];
  int          cnt [4];
  logic [3:0]  adone = '0;
  logic [3:0]  st;
  int          fs_cnt, ct_cnt, cs_cnt, ws_cnt, done_cnt;
  int          model_err, stab_err, grant_err;
  logic [17:0] fs_hold, ws_hold;
  logic [17:0] fs_log [2400];
  logic [17:0] ws_log [2400];
  logic        wsy_log [2400];

  assign st              = {bus.WS_start, bus.CS_start, bus.CT_start, bus.FS_start};
  assign bus.FS_done     = adone[0];
  assign bus.CT_done     = adone[1];
  assign bus.CS_done     = adone[2];
  assign bus.WS_done     = adone[3] | ws_stray;
  assign bus.FS_sram_req = fs_req;
  assign bus.WS_sram_req = ws_req;

  function automatic logic [17:0] exp_fs(input int b);
    int k;
    if (b < 1200) return 18'(76800 + (b / 40) * 2560 + (b % 40) * 8);
    k = (b - 1200) % 600;
    return 18'((b < 1800 ? 153600 : 192000) + (k / 20) * 1280 + (k % 20) * 8);
  endfunction

  function automatic logic [17:0] exp_ws(input int b);
    int k;
    if (b < 1200) return 18'((b / 40) * 1280 + (b % 40) * 4);
    k = (b - 1200) % 600;
    return 18'((b < 1800 ? 38400 : 57600) + (k / 20) * 640 + (k % 20) * 4);
  endfunction

  // Engine models: done fires lat cycles after the start cycle; monitor tallies pulses and addresses.
  always @(negedge Clock) begin
    for (int e = 0; e < 4; e++) begin
      if (Resetn !== 1'b1) begin
        cnt[e]   <= 0;
        adone[e] <= 1'b0;
      end else if (st[e]) begin
        cnt[e]   <= lat[e];
        adone[e] <= 1'b0;
      end else if (cnt[e] > 0) begin
        cnt[e]   <= cnt[e] - 1;
        adone[e] <= (cnt[e] == 1);
      end else begin
        adone[e] <= 1'b0;
      end
    end
    if (frame_clr) begin
      fs_cnt <= 0; ct_cnt <= 0; cs_cnt <= 0; ws_cnt <= 0; done_cnt <= 0;
      model_err <= 0; stab_err <= 0; grant_err <= 0;
    end else begin
      if (bus.FS_start) begin
        if (bus.FS_base_addr !== exp_fs(fs_cnt)) model_err <= model_err + 1;
        if (fs_cnt < 2400) fs_log[fs_cnt] <= bus.FS_base_addr;
        fs_hold <= bus.FS_base_addr;
        fs_cnt  <= fs_cnt + 1;
      end
      if (bus.CT_start) ct_cnt <= ct_cnt + 1;
      if (bus.CS_start) cs_cnt <= cs_cnt + 1;
      if (bus.WS_start) begin
        if (bus.WS_base_addr !== exp_ws(ws_cnt) || bus.WS_y_seg !== (ws_cnt < 1200))
          model_err <= model_err + 1;
        if (ws_cnt < 2400) begin
          ws_log[ws_cnt]  <= bus.WS_base_addr;
          wsy_log[ws_cnt] <= bus.WS_y_seg;
        end
        ws_hold <= bus.WS_base_addr;
        ws_cnt  <= ws_cnt + 1;
      end
      if (Resetn === 1'b1 && !st[0] && cnt[0] == 1 && bus.FS_base_addr !== fs_hold)
        stab_err <= stab_err + 1;
      if (Resetn === 1'b1 && !st[3] && cnt[3] == 1 && bus.WS_base_addr !== ws_hold)
        stab_err <= stab_err + 1;
      if (M2_done === 1'b1) done_cnt <= done_cnt + 1;
      if ((bus.FS_sram_grant && bus.WS_sram_grant) ||
          (bus.CT_start && !(bus.WS_sram_grant && !bus.FS_sram_grant)) ||
          (bus.CS_start && !(bus.FS_sram_grant && !bus.WS_sram_grant)))
        grant_err <= grant_err + 1;
    end
  end

  task automatic step();
    @(posedge Clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    frame_clr = 1'b1;
    step();
    frame_clr = 1'b0;
    Enable = 1'b1;
    step();
    Enable = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (M2_done !== 1'b1 && n < 25000) begin
      step();
      n++;
    end
    chk(tag, 32'(M2_done), 32'd1);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_fs_starts"}, 32'(fs_cnt), 32'd2400);
    chk({tag, "_ct_starts"}, 32'(ct_cnt), 32'd2400);
    chk({tag, "_cs_starts"}, 32'(cs_cnt), 32'd2400);
    chk({tag, "_ws_starts"}, 32'(ws_cnt), 32'd2400);
    chk({tag, "_model_err"}, 32'(model_err), 32'd0);
    chk({tag, "_stab_err"}, 32'(stab_err), 32'd0);
    chk({tag, "_grant_err"}, 32'(grant_err), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_starts"}, 32'({bus.FS_start, bus.CT_start, bus.CS_start, bus.WS_start}), 32'd0);
    chk({tag, "_fs_addr"}, 32'(bus.FS_base_addr), 32'd0);
    chk({tag, "_ws_addr"}, 32'(bus.WS_base_addr), 32'd0);
    chk({tag, "_ws_y"}, 32'(bus.WS_y_seg), 32'd0);
    chk({tag, "_grants"}, 32'({bus.FS_sram_grant, bus.WS_sram_grant}), 32'd0);
    chk({tag, "_m2_done"}, 32'(M2_done), 32'd0);
    chk({tag, "_m2_err"}, 32'(M2_err), 32'd0);
  endtask

  initial begin
    int k;
    Resetn = 1'b0; Enable = 1'b0; fs_req = 1'b1; ws_req = 1'b1;
    ws_stray = 1'b0; frame_clr = 1'b0;
    for (int e = 0; e < 4; e++) lat[e] = 3;
    repeat (3) step();
    chk_zero("reset");
    Resetn = 1'b1;
    step();

    // Frame 1: all engines 3 cycles, stray Enable mid-frame must be ignored
    start_frame();
    chk("f1_first_fs_start", 32'(bus.FS_start), 32'd1);
    chk("f1_first_fs_addr", 32'(bus.FS_base_addr), 32'd76800);
    repeat (100) step();
    Enable = 1'b1;
    step();
    Enable = 1'b0;
    wait_done("f1_done_seen");
    chk_counts("f1");
    chk("f1_fs_blk1", 32'(fs_log[1]), 32'd76808);
    chk("f1_fs_blk40", 32'(fs_log[40]), 32'd79360);
    chk("f1_fs_blk1200", 32'(fs_log[1200]), 32'd153600);
    chk("f1_ws_blk1200", 32'(ws_log[1200]), 32'd38400);
    chk("f1_wsy_blk1200", 32'(wsy_log[1200]), 32'd0);
    chk("f1_wsy_blk0", 32'(wsy_log[0]), 32'd1);
    chk("f1_fs_blk1800", 32'(fs_log[1800]), 32'd192000);
    chk("f1_ws_blk1800", 32'(ws_log[1800]), 32'd57600);
    chk("f1_fs_blk2399", 32'(fs_log[2399]), 32'd229272);
    chk("f1_ws_blk2399", 32'(ws_log[2399]), 32'd76236);
    chk("f1_m2_err", 32'(M2_err), 32'd0);
    step();
    chk("f1_done_one_cycle", 32'(M2_done), 32'd0);
    chk("f1_done_count", 32'(done_cnt), 32'd1);
`ifdef M2_SCHED_PERF_CNT_EN
    chk("f1_cycles", M2_cycles, 32'd19210);
`endif
    repeat (3) step();
    chk("f1_idle_no_start", 32'(bus.FS_start), 32'd0);

    // Frame 2: slow PH_B (CS 2, FS 9 cycles) then a stray WS_done in PH_B
    start_frame();
    k = 0;
    while (!(bus.CT_start === 1'b1 && ct_cnt >= 3) && k < 200) begin step(); k++; end
    chk("f2_reach_ph_a", 32'(bus.CT_start), 32'd1);
    lat[2] = 2;
    lat[0] = 9;
    k = 0;
    while (bus.CS_start !== 1'b1 && k < 20) begin step(); k++; end
    chk("f2_reach_ph_b", 32'(bus.CS_start), 32'd1);
    k = 0;
    do begin
      step();
      k++;
      if (k == 1) begin lat[2] = 3; lat[0] = 3; end
    end while (bus.CT_start !== 1'b1 && k < 20);
    chk("f2_ph_a_entry_cycle", 32'(k), 32'd10);
    k = 0;
    while (bus.CS_start !== 1'b1 && k < 20) begin step(); k++; end
    step();
    chk("f2_fs_grant_ph_b", 32'({bus.FS_sram_grant, bus.WS_sram_grant}), 32'd2);
    fs_req = 1'b0;
    #1;
    chk("f2_fs_grant_no_req", 32'(bus.FS_sram_grant), 32'd0);
    fs_req = 1'b1;
    chk("f2_err_before_stray", 32'(M2_err), 32'd0);
    ws_stray = 1'b1;
    step();
    ws_stray = 1'b0;
    chk("f2_err_after_stray", 32'(M2_err), 32'd1);
    wait_done("f2_done_seen");
    chk_counts("f2");
    step();
    chk("f2_err_held", 32'(M2_err), 32'd1);
    chk("f2_done_count", 32'(done_cnt), 32'd1);

    // Frame 3: reset during PH_A of block 500, then a clean restart
    start_frame();
    k = 0;
    while (!(bus.CT_start === 1'b1 && ct_cnt == 500) && k < 10000) begin step(); k++; end
    chk("f3_reach_blk500", 32'(bus.CT_start), 32'd1);
    Resetn = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) step();
    Resetn = 1'b1;
    step();
    start_frame();
    chk("f4_fs_start", 32'(bus.FS_start), 32'd1);
    chk("f4_fs_addr", 32'(bus.FS_base_addr), 32'd76800);
    wait_done("f4_done_seen");
    chk_counts("f4");
    chk("f4_m2_err", 32'(M2_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/m2_block_scheduler.md
M2_BLOCK_SCHEDULER -- requirements
Module: m2_block_scheduler

Interface
REQ-001 SHALL have ports: Clock  in  1  system clock; Resetn  in  1  asynchronous active-low reset.
REQ-002 SHALL have port Enable  in  1  start pulse for one full-frame decode.
REQ-003 SHALL have ports FS_start/CT_start/CS_start/WS_start  out  1 each  one-cycle start pulses to the fetch-S', compute-T, compute-S and write-S engines.
REQ-004 SHALL have ports FS_done/CT_done/CS_done/WS_done  in  1 each  one-cycle completion pulses from those engines.
REQ-005 SHALL have ports FS_base_addr  out  18  pre-IDCT block base; WS_base_addr  out  18  post-IDCT block base; WS_y_seg  out  1  1 when the block being written is Y.
REQ-006 SHALL have ports FS_sram_req, WS_sram_req  in  1; FS_sram_grant, WS_sram_grant  out  1  SRAM port ownership.
REQ-007 SHALL have ports M2_done  out  1  one-cycle frame-complete pulse; M2_err  out  1  sticky protocol error.

Function
REQ-008 Block order SHALL be Y (40 cols x 30 rows), then U (20x30), then V (20x30), column-major within a row, 2400 blocks total; separate FS and WS counters (col, row, seg).
REQ-009 FS_base_addr SHALL be 76800 + row*2560 + col*8 (Y); 153600 + row*1280 + col*8 (U); 192000 + row*1280 + col*8 (V).
REQ-010 WS_base_addr SHALL be row*1280 + col*4 (Y); 38400 + row*640 + col*4 (U); 57600 + row*640 + col*4 (V).
REQ-011 FSM states: IDLE, LI_FS, PH_A, PH_B, LO_WS, DONE.
REQ-012 IDLE: Enable=1 -> LI_FS with FS_start; Enable in any other state SHALL be ignored.
REQ-013 LI_FS: fetch block 0; FS_done -> PH_A.
REQ-014 PH_A (block n): CT_start, plus WS_start for block n-1 when n>0, both in the entry cycle.
REQ-015 PH_B (block n): CS_start, plus FS_start for block n+1 when n<2399.
REQ-016 Each phase SHALL latch done pulses into per-engine flags and advance the cycle after all engines started in that phase have reported done; flags clear on advance.
REQ-017 PH_B of block 2399 -> LO_WS (WS_start, block 2399); WS_done -> DONE; DONE asserts M2_done for 1 cycle -> IDLE.
REQ-018 FS counter SHALL advance on FS_done, WS counter on WS_done; col wraps to 0 with row+1; row 29 wrap advances seg Y->U->V.
REQ-019 Base addresses SHALL be registered and stable from the FS_start/WS_start cycle until the matching done.
REQ-020 Grant SHALL equal req AND ownership; FS owns SRAM in LI_FS and PH_B, WS in PH_A and LO_WS; both grants never high together.
REQ-021 A done pulse from an engine not started in the current phase, or a second done in one phase, SHALL set M2_err and be otherwise ignored.
REQ-022 Done pulses in the same cycle as the phase start pulse SHALL be treated as errors (minimum engine latency 1 cycle).

Reset
REQ-023 Resetn low SHALL force IDLE, all counters, flags and base addresses to 0, and all start, grant, M2_done and M2_err outputs to 0.
REQ-024 Reset mid-frame SHALL abandon the frame; the next Enable restarts at block 0.

Configuration
REQ-025 Macro M2_SCHED_PERF_CNT_EN: when defined, SHALL add output M2_cycles (32 bits) counting cycles from the Enable-accept cycle through DONE inclusive, held until the next Enable and cleared by reset; when undefined, the port and counter SHALL be absent and all other behaviour unchanged.

Verification
REQ-026 Enable, all engines done 3 cycles after start -> first FS_base_addr=76800, FS for block 1 = 76808, FS for block 40 = 79360.
REQ-027 Full frame -> 2400 FS_start, CT_start, CS_start and WS_start pulses each; exactly one M2_done; M2_err=0.
REQ-028 Block 1200 -> FS_base_addr=153600, WS_base_addr=38400, WS_y_seg=0; block 1800 -> 192000/57600.
REQ-029 In PH_B, CS_done at cycle 2 and FS_done at cycle 9 -> PH_A entered at cycle 10, not earlier.
REQ-030 Stray WS_done during PH_B -> M2_err=1 and held; schedule continues unchanged.
REQ-031 Resetn low during PH_A of block 500 -> all outputs 0; Enable afterwards -> FS_base_addr=76800.
